// File: rtl/if_id_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_id_queue_pkg
//   Shared constants and types for the IF/ID fetch decoupling queue.
//   WORD_LEN  : width of PC and instruction words
//   IFQ_DEPTH : default number of queue entries (power of two, >= 2)
//   ifq_entry_t : one buffered {pc, instr} pair as stored in the queue
// ----------------------------------------------------------------------------
package if_id_queue_pkg;

    localparam int WORD_LEN  = 32;
    localparam int IFQ_DEPTH = 4;

    typedef struct packed {
        logic [WORD_LEN-1:0] pc;
        logic [WORD_LEN-1:0] instr;
    } ifq_entry_t;

    // Decoder NOP presented to ID whenever the queue is empty.
    localparam logic [WORD_LEN-1:0] IFQ_NOP = '0;

endpackage

// File: rtl/ifq_mem.sv
// ----------------------------------------------------------------------------
// ifq_mem
//   DEPTH x WIDTH register array, one synchronous write port and one
//   asynchronous read port. Contents are not reset; validity is tracked
//   by the owning queue's occupancy count.
//   Ports:
//     clk   : rising-edge clock
//     we    : write enable
//     waddr : write address
//     wdata : write data
//     raddr : read address
//     rdata : read data (combinational from the array)
// ----------------------------------------------------------------------------
module ifq_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//   Small in-order queue decoupling IFStage from ID. Fetch pushes
//   {pc, instr} pairs, decode pops the head. A full queue freezes fetch;
//   a taken branch/jump (flush) discards everything buffered.
//   Ports:
//     clk       : rising-edge clock
//     rst       : asynchronous active-low reset
//     flush     : taken-branch redirect, empties the queue on the next edge
//     in_valid  : fetch presents a valid pair
//     in_pc     : PC of the fetched instruction
//     in_instr  : fetched instruction word
//     if_freeze : to IFStage, high while the queue is full
//     id_freeze : decode stall, holds the head entry
//     out_valid : head entry valid
//     out_pc    : head PC (0 when empty)
//     out_instr : head instruction (NOP/0 when empty)
//     count     : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int WORD_LEN = if_id_queue_pkg::WORD_LEN,
    parameter int DEPTH    = IFQ_DEPTH,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [WORD_LEN-1:0] in_pc,
    input  logic [WORD_LEN-1:0] in_instr,
    output logic                if_freeze,
    input  logic                id_freeze,
    output logic                out_valid,
    output logic [WORD_LEN-1:0] out_pc,
    output logic [WORD_LEN-1:0] out_instr,
    output logic [PTR_W:0]      count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic                  full, empty, push, pop;
    logic [2*WORD_LEN-1:0] rdata;

    // Status comes straight off the count register; full/empty are
    // never ambiguous because count spans 0..DEPTH.
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign if_freeze = full;
    assign out_valid = !empty;

    // Flush wins over everything. Full is judged on the current count,
    // so a pop while full does not open a slot for this cycle's push.
    assign push = in_valid && !full && !flush;
    assign pop  = out_valid && !id_freeze && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointer width is log2(DEPTH), so +1 wraps DEPTH-1 -> 0 for free.
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    ifq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_LEN),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Stale array contents must never reach decode: force zero when empty.
    assign out_pc    = empty ? '0 : rdata[2*WORD_LEN-1:WORD_LEN];
    assign out_instr = empty ? '0 : rdata[WORD_LEN-1:0];

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- 4-entry fetch decoupling queue between IFStage and the ID stage.
- Captures {PC, instruction} pairs from fetch and presents them in order to decode.
- Back-pressures fetch through its freeze input when full.
- Discards all buffered entries on a taken branch/jump (flush).

Parameters:
WORD_LEN, 32, width of PC and instruction words (matches `WORD_LEN in defines.v)
DEPTH, 4, number of queue entries; must be a power of two, minimum 2
PTR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
flush  input  1  taken branch/jump redirect (same source as IFStage branch_Taken); empties queue
in_valid  input  1  fetch presents a valid pair this cycle
in_pc  input  WORD_LEN  PC of the fetched instruction
in_instr  input  WORD_LEN  fetched instruction word
if_freeze  output  1  to IFStage freeze; high when the queue is full
id_freeze  input  1  decode stall; hold the head entry
out_valid  output  1  head entry valid for decode
out_pc  output  WORD_LEN  PC of head entry
out_instr  output  WORD_LEN  instruction of head entry; 32'h0 (NOP) when out_valid=0
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid=0, out_pc=0, out_instr=0.
  - Storage array contents are don't-care.
  - Release is synchronous to clk; the first push is possible on the first rising edge with rst=1.
- Status:
  - full = (count==DEPTH); if_freeze = full (combinational from the count register).
  - empty = (count==0); out_valid = !empty.
- Push: push = in_valid && !full && !flush. Writes mem[wr_ptr] <= {in_pc, in_instr}; wr_ptr increments modulo DEPTH.
- Pop: pop = out_valid && !id_freeze && !flush. rd_ptr increments modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
- Outputs:
  - out_pc/out_instr read mem[rd_ptr] combinationally from registered storage.
  - Forced to 0 when empty.
- Latency: there is no bypass. A pair pushed at edge N is visible at out_* after edge N (one cycle fetch-to-decode, same as a plain IF/ID register).
- Ordering: strict FIFO; pairs leave in push order.
- Full boundary:
  - When full, in_valid is ignored. IFStage holds its PC via if_freeze, so nothing is lost.
  - A simultaneous pop while full does not admit a push in the same cycle (full is evaluated on the current count). if_freeze drops in the following cycle.
- Empty boundary: a pop request with empty is impossible (out_valid=0); pointers never move.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no special casing. count distinguishes full from empty.
- Flush:
  - Highest priority; synchronous.
  - Next edge sets count=0 and rd_ptr=wr_ptr=0. out_valid is 0 the cycle after.
  - A push or pop coincident with flush is discarded.
  - The redirected fetch arrives with in_valid in the following cycle and is accepted normally.
- id_freeze with empty: no effect.
- id_freeze with valid head: out_* held stable every cycle until released.
- Reset mid-operation: all state is lost immediately; outputs go to reset values without waiting for clk.

Decomposition:
- defines.v (shared): WORD_LEN, and an IFQ_DEPTH default constant.
- One natural sub-module: ifq_mem, a DEPTH x (2*WORD_LEN) register array.
  - One write port (we, waddr, wdata); one asynchronous read port (raddr, rdata).
  - No reset on its contents.
- Pointer/count control stays in if_id_queue.

Test Plan:
- Reset then single push: rst low 3 cycles, release. Push in_pc=32'h0, in_instr=32'h2008_0005 -> next cycle out_valid=1, out_pc=0, out_instr=32'h2008_0005, count=1. With id_freeze=0, queue is empty the cycle after.
- Fill to full: id_freeze=1, push PCs 0,4,8,12 -> count=4, if_freeze=1. Fifth in_valid (PC=16) is ignored. Release id_freeze -> outputs PCs 0,4,8,12 in order; if_freeze falls one cycle after the first pop.
- Wrap-around: steady push+pop for 10 cycles with PCs 0..36 -> count stays 1, out_pc sequence 0,4,...,36 with one-cycle lag, pointers wrap twice.
- Flush with coincident push/pop: count=3, assert flush with in_valid=1 (PC=32'h40) and id_freeze=0 -> next cycle count=0, out_valid=0, out_instr=0, PC 32'h40 absent. Push of target PC=32'h100 is accepted the following cycle.
- Decode stall hold: head PC=8 with id_freeze=1 for 5 cycles while pushing PCs 12,16 -> out_pc=8 stable for all 5 cycles, count rises 1->3. Release -> 8,12,16 are delivered.
- Asynchronous reset mid-stream: count=2, pull rst low between clock edges -> out_valid, count and out_pc go to 0 immediately. After release, the first push appears one cycle later with count=1.
